// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window sequencer and its coordinate calculators.
package conv_pkg;

    localparam int unsigned STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed input coordinates need one extra bit so that negative (padded) positions are representable.
    function automatic int unsigned coord_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/input_coordinate_calc.sv
// Maps an output index and kernel tap onto a signed input coordinate: out*STRIDE + k - PADDING.
module input_coordinate_calc
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned STRIDE     = 1,
    parameter int unsigned PADDING    = 1
) (
    input  logic        [ADDR_WIDTH-1:0]              out_idx,
    input  logic        [ADDR_WIDTH-1:0]              k_idx,
    output logic signed [coord_width(ADDR_WIDTH)-1:0] in_coord_c
);

    localparam int unsigned CW = coord_width(ADDR_WIDTH);

    logic [CW-1:0] scaled;
    logic [CW-1:0] summed;

    // Operands are zero-extended into the wider signed domain before the padding subtraction.
    assign scaled     = CW'(out_idx) * CW'(STRIDE);
    assign summed     = scaled + CW'(k_idx);
    assign in_coord_c = signed'(summed - CW'(PADDING));

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every output pixel and kernel tap of one convolution pass, one coordinate beat per tap.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned PADDING     = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic        [ADDR_WIDTH-1:0]              out_h,
    input  logic        [ADDR_WIDTH-1:0]              out_w,
    input  logic        [ADDR_WIDTH-1:0]              in_h,
    input  logic        [ADDR_WIDTH-1:0]              in_w,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      coord_valid,
    input  logic                                      coord_ready,
    output logic        [ADDR_WIDTH-1:0]              out_row,
    output logic        [ADDR_WIDTH-1:0]              out_col,
    output logic        [ADDR_WIDTH-1:0]              k_row,
    output logic        [ADDR_WIDTH-1:0]              k_col,
    output logic signed [coord_width(ADDR_WIDTH)-1:0] in_row,
    output logic signed [coord_width(ADDR_WIDTH)-1:0] in_col,
    output logic                                      pad,
    output logic                                      first_tap,
    output logic                                      last_tap,
    output logic                                      last_window
);

    localparam int unsigned          CW     = coord_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

    state_t state_q;
    state_t state_d;

    logic [ADDR_WIDTH-1:0] out_h_q;
    logic [ADDR_WIDTH-1:0] out_w_q;
    logic [ADDR_WIDTH-1:0] in_h_q;
    logic [ADDR_WIDTH-1:0] in_w_q;

    logic start_ok_c;
    logic xfer_c;
    logic k_col_wrap_c;
    logic k_row_wrap_c;
    logic out_col_wrap_c;
    logic out_row_last_c;
    logic empty_req_c;

    logic signed [CW-1:0] in_h_s;
    logic signed [CW-1:0] in_w_s;

    // Handshake and loop-wrap decode.
    assign start_ok_c     = start & (state_q == ST_IDLE);
    assign empty_req_c    = (out_h == '0) | (out_w == '0);
    assign xfer_c         = coord_valid & coord_ready;
    assign k_col_wrap_c   = (k_col == K_LAST);
    assign k_row_wrap_c   = (k_row == K_LAST);
    assign out_col_wrap_c = (out_col == out_w_q - ONE);
    assign out_row_last_c = (out_row == out_h_q - ONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: an empty output plane skips straight to the done cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = empty_req_c ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer_c && last_window) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state register only, so they are glitch-free and reset asynchronously.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        coord_valid = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                busy        = 1'b1;
                coord_valid = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Size latch and nested loop counters; k_col is innermost, out_row outermost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_h_q <= '0;
            out_w_q <= '0;
            in_h_q  <= '0;
            in_w_q  <= '0;
            out_row <= '0;
            out_col <= '0;
            k_row   <= '0;
            k_col   <= '0;
        end else if (start_ok_c) begin
            out_h_q <= out_h;
            out_w_q <= out_w;
            in_h_q  <= in_h;
            in_w_q  <= in_w;
            out_row <= '0;
            out_col <= '0;
            k_row   <= '0;
            k_col   <= '0;
        end else if (xfer_c) begin
            if (last_window) begin
                out_row <= '0;
                out_col <= '0;
                k_row   <= '0;
                k_col   <= '0;
            end else if (!k_col_wrap_c) begin
                k_col <= k_col + ONE;
            end else begin
                k_col <= '0;
                if (!k_row_wrap_c) begin
                    k_row <= k_row + ONE;
                end else begin
                    k_row <= '0;
                    if (!out_col_wrap_c) begin
                        out_col <= out_col + ONE;
                    end else begin
                        out_col <= '0;
                        out_row <= out_row + ONE;
                    end
                end
            end
        end
    end

    // Row and column input coordinate calculators.
    input_coordinate_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRIDE     (STRIDE),
        .PADDING    (PADDING)
    ) u_row_calc (
        .out_idx    (out_row),
        .k_idx      (k_row),
        .in_coord_c (in_row)
    );

    input_coordinate_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRIDE     (STRIDE),
        .PADDING    (PADDING)
    ) u_col_calc (
        .out_idx    (out_col),
        .k_idx      (k_col),
        .in_coord_c (in_col)
    );

    // Padding test against the latched input size, plus window markers.
    always_comb begin
        in_h_s      = signed'({1'b0, in_h_q});
        in_w_s      = signed'({1'b0, in_w_q});
        pad         = in_row[CW-1] | (in_row >= in_h_s) | in_col[CW-1] | (in_col >= in_w_s);
        first_tap   = (k_row == '0) & (k_col == '0);
        last_tap    = k_row_wrap_c & k_col_wrap_c;
        last_window = last_tap & out_row_last_c & out_col_wrap_c;
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer: default instance plus a stride-2, no-padding instance.
module tb_conv_window_sequencer;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start;
    logic [AW-1:0] out_h, out_w, in_h, in_w;
    logic          busy, done, coord_valid, coord_ready;
    logic [AW-1:0] out_row, out_col, k_row, k_col;
    logic [AW:0]   in_row, in_col;
    logic          pad, first_tap, last_tap, last_window;

    logic          start_b, busy_b, done_b, valid_b, ready_b;
    logic [AW-1:0] out_row_b, out_col_b, k_row_b, k_col_b;
    logic [AW:0]   in_row_b, in_col_b;
    logic          pad_b, first_b, last_b, lastwin_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_window_sequencer #(.ADDR_WIDTH(AW), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .out_h(out_h), .out_w(out_w), .in_h(in_h), .in_w(in_w),
        .busy(busy), .done(done), .coord_valid(coord_valid), .coord_ready(coord_ready),
        .out_row(out_row), .out_col(out_col), .k_row(k_row), .k_col(k_col),
        .in_row(in_row), .in_col(in_col), .pad(pad),
        .first_tap(first_tap), .last_tap(last_tap), .last_window(last_window)
    );

    conv_window_sequencer #(.ADDR_WIDTH(AW), .KERNEL_SIZE(3), .STRIDE(2), .PADDING(0)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .out_h(8'd2), .out_w(8'd2), .in_h(8'd5), .in_w(8'd5),
        .busy(busy_b), .done(done_b), .coord_valid(valid_b), .coord_ready(ready_b),
        .out_row(out_row_b), .out_col(out_col_b), .k_row(k_row_b), .k_col(k_col_b),
        .in_row(in_row_b), .in_col(in_col_b), .pad(pad_b),
        .first_tap(first_b), .last_tap(last_b), .last_window(lastwin_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference beat: {out_row,out_col,k_row,k_col,in_row,in_col,pad,first,last,last_window}.
    function automatic logic [53:0] model(input int orow, input int ocol, input int kr, input int kc,
                                          input int h, input int w, input int ih, input int iw,
                                          input int k, input int s, input int p);
        int   ir;
        int   ic;
        logic pd;
        logic lt;
        ir = orow * s + kr - p;
        ic = ocol * s + kc - p;
        pd = (ir < 0) || (ir >= ih) || (ic < 0) || (ic >= iw);
        lt = (kr == k - 1) && (kc == k - 1);
        return {8'(orow), 8'(ocol), 8'(kr), 8'(kc), 9'(ir), 9'(ic), pd,
                (kr == 0) && (kc == 0), lt, lt && (orow == h - 1) && (ocol == w - 1)};
    endfunction

    function automatic logic [53:0] obs_a();
        return {out_row, out_col, k_row, k_col, in_row, in_col, pad, first_tap, last_tap, last_window};
    endfunction

    task automatic start_pass(input int h, input int w, input int ih, input int iw);
        out_h = 8'(h); out_w = 8'(w); in_h = 8'(ih); in_w = 8'(iw);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes one pass beat by beat, starting at the first negedge after the start pulse.
    task automatic collect(input int h, input int w, input int ih, input int iw, input bit rnd,
                           input int inj, input int abort_at, input bit start_in_done);
        int   idx;
        int   cyc;
        int   total;
        logic xfer;
        bit   hand;
        idx   = 0;
        cyc   = 0;
        total = h * w * 9;
        hand  = (h == 2) && (w == 2) && (ih == 2) && (iw == 2);
        while (idx < total && cyc < 2000) begin
            cyc++;
            check("valid", 64'(coord_valid), 64'd1);
            check("beat", 64'(obs_a()), 64'(model(idx / (9 * w), (idx / 9) % w, (idx / 3) % 3, idx % 3,
                                                  h, w, ih, iw, 3, 1, 1)));
            if (hand && idx == 0) begin
                check("b0_in_row", 64'(in_row), 64'h1ff);
                check("b0_in_col", 64'(in_col), 64'h1ff);
                check("b0_pad", 64'(pad), 64'd1);
                check("b0_first", 64'(first_tap), 64'd1);
            end
            if (hand && idx == 4) begin
                check("b4_in", 64'({in_row, in_col}), 64'h0);
                check("b4_pad", 64'(pad), 64'd0);
            end
            if (hand && idx == 35) begin
                check("b35_in", 64'({in_row, in_col}), 64'({9'd2, 9'd2}));
                check("b35_flags", 64'({pad, last_tap, last_window}), 64'b111);
            end
            if (idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid", 64'(coord_valid), 64'd0);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (idx == inj) begin
                start = 1'b1; out_h = 8'd3; out_w = 8'd3; in_h = 8'd9; in_w = 8'd9;
            end else begin
                start = 1'b0;
            end
            coord_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer = coord_valid && coord_ready;
            @(negedge clk);
            if (xfer) idx++;
        end
        start = 1'b0;
        coord_ready = 1'b1;
        check("beat_count", 64'(idx), 64'(total));
        check("done_pulse", 64'({done, busy, coord_valid}), 64'b110);
        if (start_in_done) begin
            start = 1'b1; out_h = 8'd1; out_w = 8'd1;
        end
        @(negedge clk);
        start = 1'b0;
        check("after_done", 64'({done, busy, coord_valid}), 64'b000);
    endtask

    initial begin
        int nb;
        start = 1'b0; out_h = '0; out_w = '0; in_h = '0; in_w = '0;
        coord_ready = 1'b1; start_b = 1'b0; ready_b = 1'b1;

        #1;
        check("rst_status", 64'({busy, done, coord_valid, valid_b}), 64'h0);
        check("rst_counters", 64'({out_row, out_col, k_row, k_col}), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2x2 pass, always ready
        start_pass(2, 2, 2, 2);
        collect(2, 2, 2, 2, 1'b0, -1, -1, 1'b0);

        // same pass with ready toggling
        start_pass(2, 2, 2, 2);
        collect(2, 2, 2, 2, 1'b1, -1, -1, 1'b0);

        // empty output width: straight to done
        start_pass(2, 0, 2, 2);
        check("empty_done", 64'({done, busy, coord_valid}), 64'b110);
        @(negedge clk);
        check("empty_idle", 64'({done, busy, coord_valid}), 64'b000);

        // starts during RUN and DONE are ignored
        start_pass(2, 2, 2, 2);
        collect(2, 2, 2, 2, 1'b0, 7, -1, 1'b1);

        // reset mid-pass, then a fresh 1x1 pass
        start_pass(3, 3, 3, 3);
        collect(3, 3, 3, 3, 1'b0, -1, 10, 1'b0);
        check("post_rst_counters", 64'({out_row, out_col, k_row, k_col}), 64'h0);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_quiet", 64'({done, busy, coord_valid}), 64'b000);
            @(negedge clk);
        end
        start_pass(1, 1, 1, 1);
        collect(1, 1, 1, 1, 1'b0, -1, -1, 1'b0);

        // stride 2, no padding instance
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        nb = 0;
        while (nb < 36) begin
            check("s2_valid", 64'(valid_b), 64'd1);
            check("s2_beat", 64'({out_row_b, out_col_b, k_row_b, k_col_b, in_row_b, in_col_b,
                                  pad_b, first_b, last_b, lastwin_b}),
                  64'(model(nb / 18, (nb / 9) % 2, (nb / 3) % 3, nb % 3, 2, 2, 5, 5, 3, 2, 0)));
            if (nb == 35) begin
                check("s2_last_in", 64'({in_row_b, in_col_b}), 64'({9'd4, 9'd4}));
                check("s2_last_pad", 64'(pad_b), 64'd0);
            end
            nb++;
            @(negedge clk);
        end
        check("s2_done", 64'({done_b, busy_b, valid_b}), 64'b110);
        @(negedge clk);
        check("s2_idle", 64'({done_b, busy_b, valid_b}), 64'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
